ksa: RTL and testbench
======================

KSA -- requirements
Module: ksa

Interface
REQ-001 The clock and reset ports SHALL be as follows. One clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset.
REQ-002 The handshake and key ports SHALL be:
- en  in  1  start request.
- rdy  out  1  idle and ready to accept en.
- key  in  24  cipher key; key[23:16] is byte 0, key[15:8] is byte 1, key[7:0] is byte 2.
REQ-003 The memory ports SHALL connect to the 256x8 S single-port RAM already filled by the init stage:
- addr  out  8  RAM address.
- rddata  in  8  RAM read data; one-cycle latency.
- wrdata  out  8  RAM write data.
- wren  out  1  RAM write enable.

Function
REQ-004 Outputs SHALL depend only on registered state; there is no combinational path from en, key or rddata to any output.
REQ-005 Start handshake:
- en is sampled only at an edge where rdy=1; that edge captures key and clears i, j and the i-mod-3 counter to 0.
- rdy=0 from the next cycle.
- en while rdy=0 is ignored.
REQ-006 Read timing: rddata in the cycle after a cycle presenting addr with wren=0 is the RAM content at that addr.
REQ-007 States: IDLE, RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J. Each non-IDLE state lasts exactly one cycle.
REQ-008 Per-state behaviour:
- IDLE: rdy=1, wren=0; goes to RD_I on accepted en.
- RD_I: addr=i, wren=0.
- CAP_I: latch si=rddata; j <= (j + rddata + keybyte[i mod 3]) mod 256.
- RD_J: addr=j (updated), wren=0.
- CAP_J: latch sj=rddata.
- WR_I: addr=i, wrdata=sj, wren=1.
- WR_J: addr=j, wrdata=si, wren=1. If i=255, go to IDLE; else i <= i+1, mod-3 counter advances (2 wraps to 0), go to RD_I.
REQ-009 The mod-3 key index SHALL come from a 2-bit counter, not a divider.
REQ-010 All arithmetic SHALL be 8-bit and discard the carry; j wraps 255->0.
REQ-011 When i=j, the swap SHALL be written in both WR states and leave S[i] unchanged.
REQ-012 Latency:
- One iteration is 6 cycles; 256 iterations is 1536 cycles.
- Counting the first cycle after the accepting edge as cycle 1, the last write is in cycle 1536 and rdy=1 from cycle 1537.
REQ-013 A new en accepted in the first cycle rdy=1 SHALL start a fresh pass on the current RAM contents.
REQ-014 wren SHALL be 1 only in WR_I and WR_J, and exactly 512 writes SHALL occur per pass.
REQ-015 When wren=0, wrdata SHALL hold its last value and is don't-care to the RAM.

Reset
REQ-016 At an edge with rst=1, the block SHALL enter IDLE with rdy=1, wren=0, addr=0, wrdata=0, i=j=0, mod-3 counter=0, and si=sj=0.
REQ-017 Reset mid-pass SHALL abort:
- no write occurs in the cycle after the reset edge;
- RAM contents stay partially permuted;
- rdy=1 the cycle after reset deasserts.
REQ-018 rst SHALL take priority over en in the same cycle.

Verification
REQ-019 Basic start, key 24'h00033C, RAM S[i]=i: assert en for one cycle with rdy=1. Required:
- rdy=0 next cycle.
- Iteration 0 writes addr0<-0 twice (j=0).
- Iteration 1 writes addr1<-4 then addr4<-1 (j=4), on cycles 11 and 12.
REQ-020 Full pass, key 24'h00033C: compare all 256 RAM bytes against a software KSA model. Required:
- exact match;
- rdy rises in cycle 1537;
- 512 writes counted.
REQ-021 Key-byte ordering, key 24'hFF0000: iteration 0 gives j=0xFF, with writes addr0<-255 then addr255<-0.
REQ-022 Ignore while busy: pulse en again at cycles 5 and 700 with a different key. Required: no effect, and the final RAM still matches the model for the original key.
REQ-023 Reset mid-pass: assert rst in cycle 300, then restart with en. Required:
- wren=0 the cycle after the reset edge;
- rdy=1 the cycle after reset deasserts;
- the second pass starts with i=j=0 and addr=0.
REQ-024 Back-to-back passes: re-assert en in the first rdy=1 cycle. Required: the second pass reads the permuted RAM, and the result matches the model applied twice.

Source files
------------

// File: rtl/ksa_if.sv
// Handshake, key and S-RAM port bundle for the key-scheduling block.
interface ksa_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  // ksa side: consumes start/key/read data, drives status and RAM controls
  modport slave (
    input  en,
    input  key,
    input  rddata,
    output rdy,
    output addr,
    output wrdata,
    output wren
  );

  // Requester / RAM side
  modport master (
    output en,
    output key,
    output rddata,
    input  rdy,
    input  addr,
    input  wrdata,
    input  wren
  );
endinterface

// File: rtl/ksa.sv
// RC4 key-scheduling pass over a 256x8 S RAM: for i=0..255,
// j += S[i] + key[i mod 3]; swap S[i], S[j]. Six cycles per iteration.
module ksa (
  input  logic  clk,
  input  logic  rst,
  ksa_if.slave  bus
);

  localparam int unsigned DW = 8;
  localparam int unsigned KW = 24;
  localparam int unsigned CW = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_I  = 3'd1,
    CAP_I = 3'd2,
    RD_J  = 3'd3,
    CAP_J = 3'd4,
    WR_I  = 3'd5,
    WR_J  = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] i_q, i_d;
  logic [DW-1:0] j_q, j_d;
  logic [CW-1:0] k3_q, k3_d;
  logic [KW-1:0] key_q, key_d;
  logic [DW-1:0] si_q, si_d;
  logic [DW-1:0] sj_q, sj_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wrdata_q, wrdata_d;
  logic          wren_q, wren_d;
  logic          rdy_q, rdy_d;
  logic [DW-1:0] key_byte_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one cycle per non-idle state, loop until i wraps past 255
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.en) state_d = RD_I;
      RD_I:    state_d = CAP_I;
      CAP_I:   state_d = RD_J;
      RD_J:    state_d = CAP_J;
      CAP_J:   state_d = WR_I;
      WR_I:    state_d = WR_J;
      WR_J:    state_d = (i_q == DW'(255)) ? IDLE : RD_I;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: index counters, captured key and the two swap operands
  always_comb begin
    i_d   = i_q;
    j_d   = j_q;
    k3_d  = k3_q;
    key_d = key_q;
    si_d  = si_q;
    sj_d  = sj_q;
    case (k3_q)
      CW'(0):  key_byte_c = key_q[23:16];
      CW'(1):  key_byte_c = key_q[15:8];
      default: key_byte_c = key_q[7:0];
    endcase
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          key_d = bus.key;
          i_d   = '0;
          j_d   = '0;
          k3_d  = '0;
        end
      end
      CAP_I: begin
        si_d = bus.rddata;
        j_d  = j_q + bus.rddata + key_byte_c;
      end
      CAP_J: sj_d = bus.rddata;
      WR_J: begin
        if (i_q != DW'(255)) begin
          i_d  = i_q + DW'(1);
          k3_d = (k3_q == CW'(2)) ? CW'(0) : k3_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs computed from the upcoming state so the registered copies line up with it
  always_comb begin
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;
    rdy_d    = (state_d == IDLE);
    case (state_d)
      RD_I: addr_d = i_d;
      RD_J: addr_d = j_d;
      WR_I: begin
        addr_d   = i_d;
        wrdata_d = sj_d;
        wren_d   = 1'b1;
      end
      WR_J: begin
        addr_d   = j_d;
        wrdata_d = si_d;
        wren_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q      <= '0;
      j_q      <= '0;
      k3_q     <= '0;
      key_q    <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      i_q      <= i_d;
      j_q      <= j_d;
      k3_q     <= k3_d;
      key_q    <= key_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.rdy    = rdy_q;
  assign bus.addr   = addr_q;
  assign bus.wrdata = wrdata_q;
  assign bus.wren   = wren_q;

endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: behavioural S RAM, KSA reference model feeding a write scoreboard.
module tb_ksa;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic ram_init;
  int   cyc = 0;
  int   start_cyc = 0;
  int   wr_cnt = 0;
  int   total = 0;
  int   bad = 0;

  logic [7:0] ram [256];
  logic [7:0] sm  [256];
  wr_t        exp_q [$];

  ksa_if bus ();

  ksa u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port S RAM, one-cycle read latency
  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 256; k++) ram[k] <= 8'(k);
    end else if (bus.wren) begin
      ram[bus.addr] <= bus.wrdata;
    end
    bus.rddata <= ram[bus.addr];
  end

  function automatic int rel();
    return cyc - start_cyc + 1;
  endfunction

  // Scoreboard monitor: every RAM write is checked against the next expected write
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.wren === 1'b1) begin
        wr_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected: got addr=%0h data=%0h cycle=%0d, required no write",
                   bus.addr, bus.wrdata, rel());
        end else begin
          e = exp_q.pop_front();
          if (bus.addr !== e.a || bus.wrdata !== e.d || rel() != e.cyc) begin
            bad++;
            $display("FAIL write: got addr=%0h data=%0h cycle=%0d, required addr=%0h data=%0h cycle=%0d",
                     bus.addr, bus.wrdata, rel(), e.a, e.d, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference KSA on sm; pushes the expected write stream for the first niter iterations
  task automatic model_pass(input logic [23:0] k, input int niter);
    logic [7:0] j;
    logic [7:0] kb;
    logic [7:0] t;
    j = 8'd0;
    for (int n = 0; n < niter; n++) begin
      case (n % 3)
        0:       kb = k[23:16];
        1:       kb = k[15:8];
        default: kb = k[7:0];
      endcase
      j = j + sm[n] + kb;
      t = sm[n];
      exp_q.push_back('{a: 8'(n), d: sm[j], cyc: 6 * n + 5});
      exp_q.push_back('{a: j, d: t, cyc: 6 * n + 6});
      sm[n] = sm[j];
      sm[j] = t;
    end
  endtask

  // Advance to the falling edge inside relative cycle k (bounded)
  task automatic goto(input int k);
    int guard;
    guard = 0;
    while (rel() != k && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (rel() != k) begin
      bad++;
      total++;
      $display("FAIL goto_timeout: got cycle %0d required %0d", rel(), k);
    end
  endtask

  // Called at a falling edge while idle; returns at the falling edge of cycle 1
  task automatic start_pass(input logic [23:0] k);
    bus.en  = 1'b1;
    bus.key = k;
    @(posedge clk);
    #1;
    bus.en    = 1'b0;
    start_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic load_identity();
    ram_init = 1'b1;
    @(posedge clk);
    #1;
    ram_init = 1'b0;
    for (int k = 0; k < 256; k++) sm[k] = 8'(k);
    @(negedge clk);
  endtask

  task automatic chk_ram(input string name);
    int mism;
    mism = 0;
    for (int k = 0; k < 256; k++) if (ram[k] !== sm[k]) mism++;
    chk(name, 32'(mism), 32'd0);
  endtask

  // Checks end of a full pass: rdy timing, write count, RAM contents
  task automatic finish_pass(input string tag, input int wr0);
    goto(1536);
    chk({tag, "_rdy_1536"}, 32'(bus.rdy), 32'd0);
    goto(1537);
    chk({tag, "_rdy_1537"}, 32'(bus.rdy), 32'd1);
    chk({tag, "_writes"}, 32'(wr_cnt - wr0), 32'd512);
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    chk_ram({tag, "_ram"});
  endtask

  initial begin
    int         wr0;
    logic [7:0] j0;
    rst      = 1'b1;
    ram_init = 1'b0;
    bus.en   = 1'b0;
    bus.key  = 24'h0;
    repeat (3) @(negedge clk);
    chk("reset_rdy", 32'(bus.rdy), 32'd1);
    chk("reset_wren", 32'(bus.wren), 32'd0);
    chk("reset_addr", 32'(bus.addr), 32'd0);
    chk("reset_wrdata", 32'(bus.wrdata), 32'd0);
    // rst and en together: reset wins, block stays idle
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    chk("rst_over_en_rdy", 32'(bus.rdy), 32'd1);
    rst = 1'b0;
    load_identity();

    // Pass A: key 00033C on identity, busy en pulses ignored
    model_pass(24'h00033C, 256);
    wr0 = wr_cnt;
    start_pass(24'h00033C);
    chk("a_rdy_cycle1", 32'(bus.rdy), 32'd0);
    goto(5);
    chk("a_c5_addr", 32'(bus.addr), 32'd0);
    chk("a_c5_data", 32'(bus.wrdata), 32'd0);
    chk("a_c5_wren", 32'(bus.wren), 32'd1);
    bus.en  = 1'b1;
    bus.key = 24'hABCDEF;
    goto(6);
    bus.en  = 1'b0;
    chk("a_c6_addr", 32'(bus.addr), 32'd0);
    chk("a_c6_data", 32'(bus.wrdata), 32'd0);
    goto(11);
    chk("a_c11_addr", 32'(bus.addr), 32'd1);
    chk("a_c11_data", 32'(bus.wrdata), 32'd4);
    chk("a_c11_wren", 32'(bus.wren), 32'd1);
    goto(12);
    chk("a_c12_addr", 32'(bus.addr), 32'd4);
    chk("a_c12_data", 32'(bus.wrdata), 32'd1);
    goto(700);
    bus.en  = 1'b1;
    bus.key = 24'h123456;
    goto(701);
    bus.en  = 1'b0;
    finish_pass("a", wr0);

    // Pass B: back-to-back restart in the first idle cycle on permuted RAM
    model_pass(24'h00033C, 256);
    wr0 = wr_cnt;
    start_pass(24'h00033C);
    chk("b_rdy_cycle1", 32'(bus.rdy), 32'd0);
    finish_pass("b", wr0);

    // Pass C: key FF0000 byte order, then reset in cycle 300
    load_identity();
    model_pass(24'hFF0000, 50);
    start_pass(24'hFF0000);
    goto(5);
    chk("c_c5_addr", 32'(bus.addr), 32'd0);
    chk("c_c5_data", 32'(bus.wrdata), 32'd255);
    goto(6);
    chk("c_c6_addr", 32'(bus.addr), 32'd255);
    chk("c_c6_data", 32'(bus.wrdata), 32'd0);
    goto(300);
    rst = 1'b1;
    goto(301);
    chk("c_wren_after_rst", 32'(bus.wren), 32'd0);
    rst = 1'b0;
    goto(302);
    chk("c_rdy_after_rst", 32'(bus.rdy), 32'd1);
    chk("c_queue_left", 32'(exp_q.size()), 32'd0);
    chk_ram("c_partial_ram");
    exp_q.delete();

    // Pass D: fresh pass on the partially permuted RAM
    j0 = sm[0];
    model_pass(24'h00033C, 256);
    wr0 = wr_cnt;
    start_pass(24'h00033C);
    chk("d_c1_addr", 32'(bus.addr), 32'd0);
    chk("d_c1_wren", 32'(bus.wren), 32'd0);
    goto(3);
    chk("d_c3_addr_j", 32'(bus.addr), 32'(j0));
    finish_pass("d", wr0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
